uvmt_cv32e40s_obi_resp_pipe: RTL and testbench

Parametrised multi-channel OBI response shim between the CV32E40S DUT wrapper's OBI master ports (instruction, data, and any future ports) and the memory-model agents. Per channel it limits outstanding transactions, buffers memory responses in order, and releases them after a programmable minimum delay. It generates the integrity signals the core expects: `gntpar`, `rvalidpar` and `rchk`. It generalises the fixed two-port hookup to `NUM_CH` channels with configurable data width, depth and latency.

---
 rtl/uvmt_cv32e40s_obi_resp_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_uvmt_cv32e40s_obi_resp_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_cv32e40s_obi_resp_pipe.sv
// uvmt_cv32e40s_obi_resp_pipe
// Multi-channel OBI response shim between the core's OBI master ports and the
// memory-model agents. Each channel limits outstanding transactions, queues
// memory responses in order and releases each one after RESP_DELAY cycles.
// It also produces the gntpar / rvalidpar / rchk integrity signals.
//
// Optional feature: define UVMT_CV32E40S_OBI_FAULT_INJ_EN to let a rising
// level on fault_inj_i corrupt rchk_o[0] of the next released response.
// Without the macro, fault_inj_i is ignored and rchk_o is always correct.
//
// A memory response that arrives when the channel has no request waiting at
// the memory (this includes the FIFO-full case) is dropped and latches
// protocol_err_o until reset.
module uvmt_cv32e40s_obi_resp_pipe #(
  parameter int NUM_CH          = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_DELAY      = 0,
  localparam int CHK_W          = DATA_WIDTH/8 + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NUM_CH-1:0]                    req_i,
  input  logic [NUM_CH-1:0][31:0]              addr_i,
  output logic [NUM_CH-1:0]                    gnt_o,
  output logic [NUM_CH-1:0]                    gntpar_o,
  output logic [NUM_CH-1:0]                    rvalid_o,
  output logic [NUM_CH-1:0]                    rvalidpar_o,
  output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    rdata_o,
  output logic [NUM_CH-1:0]                    err_o,
  output logic [NUM_CH-1:0][CHK_W-1:0]         rchk_o,
  output logic [NUM_CH-1:0]                    mem_req_o,
  output logic [NUM_CH-1:0][31:0]              mem_addr_o,
  input  logic [NUM_CH-1:0]                    mem_gnt_i,
  input  logic [NUM_CH-1:0]                    mem_rvalid_i,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    mem_rdata_i,
  input  logic [NUM_CH-1:0]                    mem_err_i,
  input  logic [NUM_CH-1:0]                    fault_inj_i,
  output logic [NUM_CH-1:0]                    protocol_err_o
);

  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int DLY_W = (RESP_DELAY > 0) ? $clog2(RESP_DELAY + 1) : 1;

  // Per-byte even parity of the data plus the error flag in the top bit.
  function automatic logic [CHK_W-1:0] calc_rchk(input logic [DATA_WIDTH-1:0] data,
                                                 input logic err);
    logic [CHK_W-1:0] chk;
    chk = {CHK_W{1'b0}};
    for (int b = 0; b < DATA_WIDTH/8; b++) begin
      chk[b] = ^data[8*b +: 8];
    end
    chk[CHK_W-1] = err;
    return chk;
  endfunction

  // FIFO pointer advance, wrapping modulo the depth.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt;
    if (ptr == PW'(MAX_OUTSTANDING - 1)) begin
      nxt = {PW{1'b0}};
    end else begin
      nxt = ptr + PW'(1);
    end
    return nxt;
  endfunction

  assign mem_addr_o = addr_i;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [OW-1:0]         outstanding_r;
    logic [OW-1:0]         count_r;
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;
    logic [MAX_OUTSTANDING-1:0] valid_r;
    logic [DATA_WIDTH-1:0] data_mem_r [MAX_OUTSTANDING];
    logic                  err_mem_r  [MAX_OUTSTANDING];
    logic [DLY_W-1:0]      dly_mem_r  [MAX_OUTSTANDING];
    logic                  perr_r;

    logic                  room_s;
    logic                  grant_s;
    logic                  accept_s;
    logic                  release_s;
    logic                  full_s;
    logic                  stray_s;
    logic                  drop_s;
    logic                  push_s;
    logic                  fault_apply_s;
    logic [CHK_W-1:0]      rchk_s;
    logic [DATA_WIDTH-1:0] rdata_s;
    logic                  err_s;

    // Request gating, release decision and drop detection for this channel.
    always_comb begin
      room_s    = (outstanding_r < OW'(MAX_OUTSTANDING));
      grant_s   = mem_gnt_i[g] & room_s;
      accept_s  = req_i[g] & grant_s;
      release_s = valid_r[rd_ptr_r] & (dly_mem_r[rd_ptr_r] == {DLY_W{1'b0}});
      full_s    = (count_r == OW'(MAX_OUTSTANDING));
      // No request is waiting at the memory when every outstanding one is queued.
      stray_s   = (outstanding_r <= count_r);
      drop_s    = mem_rvalid_i[g] & (full_s | stray_s);
      push_s    = mem_rvalid_i[g] & ~drop_s;
    end

`ifdef UVMT_CV32E40S_OBI_FAULT_INJ_EN
    logic fault_prev_r;
    logic fault_arm_r;

    // An arm in the same cycle as a release corrupts that release directly.
    assign fault_apply_s = fault_arm_r | (fault_inj_i[g] & ~fault_prev_r);

    // Edge detect on fault_inj_i and hold the arm until a release consumes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fault_prev_r <= 1'b0;
        fault_arm_r  <= 1'b0;
      end else begin
        fault_prev_r <= fault_inj_i[g];
        if (release_s) begin
          fault_arm_r <= 1'b0;
        end else if (fault_apply_s) begin
          fault_arm_r <= 1'b1;
        end else begin
          fault_arm_r <= fault_arm_r;
        end
      end
    end
`else
    logic unused_fault_s;
    assign unused_fault_s = fault_inj_i[g];
    assign fault_apply_s  = 1'b0;
`endif

    // Response outputs are forced to zero whenever nothing is released.
    always_comb begin
      rdata_s = {DATA_WIDTH{1'b0}};
      err_s   = 1'b0;
      rchk_s  = {CHK_W{1'b0}};
      if (release_s) begin
        rdata_s = data_mem_r[rd_ptr_r];
        err_s   = err_mem_r[rd_ptr_r];
        rchk_s  = calc_rchk(data_mem_r[rd_ptr_r], err_mem_r[rd_ptr_r])
                  ^ {{(CHK_W-1){1'b0}}, fault_apply_s};
      end else begin
        rdata_s = {DATA_WIDTH{1'b0}};
      end
    end

    // Outstanding counter: grant adds, release retires, both cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        outstanding_r <= {OW{1'b0}};
      end else begin
        case ({accept_s, release_s})
          2'b10:   outstanding_r <= outstanding_r + OW'(1);
          2'b01:   outstanding_r <= (outstanding_r != {OW{1'b0}}) ? outstanding_r - OW'(1)
                                                                  : outstanding_r;
          default: outstanding_r <= outstanding_r;
        endcase
      end
    end

    // In-order response FIFO with a per-entry hold-off counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wr_ptr_r <= {PW{1'b0}};
        rd_ptr_r <= {PW{1'b0}};
        count_r  <= {OW{1'b0}};
        valid_r  <= {MAX_OUTSTANDING{1'b0}};
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          data_mem_r[i] <= {DATA_WIDTH{1'b0}};
          err_mem_r[i]  <= 1'b0;
          dly_mem_r[i]  <= {DLY_W{1'b0}};
        end
      end else begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
          if (valid_r[i] && (dly_mem_r[i] != {DLY_W{1'b0}})) begin
            dly_mem_r[i] <= dly_mem_r[i] - DLY_W'(1);
          end
        end
        if (release_s) begin
          valid_r[rd_ptr_r] <= 1'b0;
          rd_ptr_r          <= next_ptr(rd_ptr_r);
        end
        // A freshly pushed entry starts its hold-off and cannot release this cycle.
        if (push_s) begin
          data_mem_r[wr_ptr_r] <= mem_rdata_i[g];
          err_mem_r[wr_ptr_r]  <= mem_err_i[g];
          dly_mem_r[wr_ptr_r]  <= DLY_W'(RESP_DELAY);
          valid_r[wr_ptr_r]    <= 1'b1;
          wr_ptr_r             <= next_ptr(wr_ptr_r);
        end
        case ({push_s, release_s})
          2'b10:   count_r <= count_r + OW'(1);
          2'b01:   count_r <= count_r - OW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    // Sticky protocol error for responses the channel was not expecting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        perr_r <= 1'b0;
      end else if (drop_s) begin
        perr_r <= 1'b1;
      end else begin
        perr_r <= perr_r;
      end
    end

    assign mem_req_o[g]      = req_i[g] & room_s;
    assign gnt_o[g]          = grant_s;
    assign gntpar_o[g]       = ~grant_s;
    assign rvalid_o[g]       = release_s;
    assign rvalidpar_o[g]    = ~release_s;
    assign rdata_o[g]        = rdata_s;
    assign err_o[g]          = err_s;
    assign rchk_o[g]         = rchk_s;
    assign protocol_err_o[g] = perr_r;
  end

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_resp_pipe.sv
// Self-checking bench for uvmt_cv32e40s_obi_resp_pipe (2 channels, 32-bit
// data, 2 outstanding, 2-cycle response delay). Accepted memory responses are
// pushed into a per-channel scoreboard with their due cycle and compared when
// rvalid_o fires.
module tb_uvmt_cv32e40s_obi_resp_pipe;
  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int MO  = 2;
  localparam int RD  = 2;
  localparam int CW  = DW/8 + 1;
`ifdef UVMT_CV32E40S_OBI_FAULT_INJ_EN
  localparam logic FLT_EN = 1'b1;
`else
  localparam logic FLT_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NCH-1:0]            req;
  logic [NCH-1:0][31:0]      addr;
  logic [NCH-1:0]            gnt;
  logic [NCH-1:0]            gntpar;
  logic [NCH-1:0]            rvalid;
  logic [NCH-1:0]            rvalidpar;
  logic [NCH-1:0][DW-1:0]    rdata;
  logic [NCH-1:0]            err;
  logic [NCH-1:0][CW-1:0]    rchk;
  logic [NCH-1:0]            mem_req;
  logic [NCH-1:0][31:0]      mem_addr;
  logic [NCH-1:0]            mem_gnt;
  logic [NCH-1:0]            mem_rvalid;
  logic [NCH-1:0][DW-1:0]    mem_rdata;
  logic [NCH-1:0]            mem_err;
  logic [NCH-1:0]            fault_inj;
  logic [NCH-1:0]            perr;

  always #5 clk = ~clk;

  uvmt_cv32e40s_obi_resp_pipe #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO), .RESP_DELAY(RD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .gnt_o(gnt),
    .gntpar_o(gntpar), .rvalid_o(rvalid), .rvalidpar_o(rvalidpar),
    .rdata_o(rdata), .err_o(err), .rchk_o(rchk), .mem_req_o(mem_req),
    .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .fault_inj_i(fault_inj),
    .protocol_err_o(perr)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    logic          flt;
    int            due;
  } exp_t;

  exp_t sbq [NCH][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic logic [CW-1:0] exp_rchk(input logic [DW-1:0] d, input logic e,
                                             input logic f);
    logic [CW-1:0] r;
    r = '0;
    for (int b = 0; b < DW/8; b++) r[b] = ^d[8*b +: 8];
    r[CW-1] = e;
    r[0]    = r[0] ^ f;
    return r;
  endfunction

  // One cycle of stimulus on channel ch; returns at the following negedge.
  task automatic tick(input int ch, input logic rq, input logic mg, input logic rv,
                      input logic [DW-1:0] d, input logic e, input logic acc,
                      input logic fi, input logic fx);
    exp_t x;
    @(posedge clk); #1;
    req = '0; mem_gnt = '0; mem_rvalid = '0; mem_rdata = '0; mem_err = '0;
    fault_inj = '0; addr = '0;
    req[ch] = rq; mem_gnt[ch] = mg; mem_rvalid[ch] = rv; mem_rdata[ch] = d;
    mem_err[ch] = e; fault_inj[ch] = fi; addr[ch] = 32'h8000_0000 + 32'(cyc);
    if (rv && acc) begin
      x.data = d; x.err = e; x.flt = fx; x.due = cyc + 1 + RD;
      sbq[ch].push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int ch, input int n);
    for (int i = 0; i < n; i++) tick(ch, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Response monitor: every released response must match the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      for (int ch = 0; ch < NCH; ch++) begin
        check("rvalidpar", rvalidpar[ch], !rvalid[ch]);
        if (rvalid[ch]) begin
          if (sbq[ch].size() == 0) begin
            check("spurious_rvalid", rvalid[ch], 1'b0);
          end else begin
            e = sbq[ch].pop_front();
            check("resp_cycle", cyc, e.due);
            check("rdata", rdata[ch], e.data);
            check("err", err[ch], e.err);
            check("rchk", rchk[ch], exp_rchk(e.data, e.err, e.flt));
          end
        end else begin
          check("rdata_idle", rdata[ch], '0);
          check("rchk_idle", rchk[ch], '0);
          if (sbq[ch].size() > 0 && sbq[ch][0].due <= cyc) begin
            check("rvalid_due", rvalid[ch], 1'b1);
            void'(sbq[ch].pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; addr = '0; mem_gnt = '0; mem_rvalid = '0; mem_rdata = '0;
    mem_err = '0; fault_inj = '0;
    repeat (3) @(negedge clk);
    check("rst_gntpar", gntpar, 2'b11);
    check("rst_rvalidpar", rvalidpar, 2'b11);
    check("rst_gnt", gnt, '0);
    check("rst_mem_req", mem_req, '0);
    check("rst_rvalid", rvalid, '0);
    check("rst_rdata", rdata, '0);
    check("rst_err", err, '0);
    check("rst_rchk", rchk, '0);
    check("rst_perr", perr, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(0, 2);

    // Grant gating and outstanding limit.
    tick(0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nogrant_gnt", gnt[0], 1'b0);
    check("nogrant_memreq", mem_req[0], 1'b1);
    check("addr_pass", mem_addr[0], addr[0]);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("g1_gnt", gnt[0], 1'b1);
    check("g1_gntpar", gntpar[0], 1'b0);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("g2_gnt", gnt[0], 1'b1);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("g3_gnt", gnt[0], 1'b0);
    check("g3_memreq", mem_req[0], 1'b0);
    check("g3_gntpar", gntpar[0], 1'b1);

    // One response; the next request is granted the cycle after its release.
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("full_gnt", gnt[0], 1'b0);
    end
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rel_gnt", gnt[0], 1'b1);
    idle(0, 1);

    // Back-to-back responses; grant coinciding with a release at outstanding 1.
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_000B, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 2);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("simul_gnt", gnt[0], 1'b1);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("out1_gnt", gnt[0], 1'b1);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("out2_gnt", gnt[0], 1'b0);

    // Fill the FIFO, then a third response is dropped and flagged.
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h1234_5601, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_drop_perr", perr[0], 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(0, 1);
    check("drop_perr", perr[0], 1'b1);
    check("drop_perr_ch1", perr[1], 1'b0);
    idle(0, 4);
    check("perr_sticky", perr[0], 1'b1);

    // Reset with two entries queued: nothing may emerge afterwards.
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_1111, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_2222, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = '0; mem_gnt = '0; mem_rvalid = '0;
    sbq[0].delete();
    @(negedge clk);
    check("midrst_rvalid", rvalid, '0);
    check("midrst_perr", perr, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(0, 6);
    check("post_rst_perr", perr[0], 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(0, 1);
    check("stray_perr", perr[0], 1'b1);
    idle(0, 3);

    // Fault injection: armed response carries a flipped rchk[0], next is clean.
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, FLT_EN);
    idle(0, 4);
    tick(0, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(0, 4);

    // Channel 1 works independently, with an error response.
    tick(1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ch1_gnt", gnt[1], 1'b1);
    check("ch0_gnt_iso", gnt[0], 1'b0);
    tick(1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1, 5);
    check("ch1_perr", perr[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
